// File: rtl/audio_src_arbiter.sv
// audio_src_arbiter: frame-synchronous arbiter that picks one stereo sample
// producer per audio frame, takes its sample over a valid/ready handshake and
// holds it on a registered bus feeding the i2s2 transmitter.
module audio_src_arbiter #(
  parameter int DATA_BITS     = 24,
  parameter int NUM_SRC       = 4,
  parameter int UNDERRUN_ZERO = 1,
  parameter int CNT_BITS      = 16,
  localparam int ID_BITS      = $clog2(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic                           mode,
  input  logic                           mute,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*DATA_BITS-1:0]   src_data_l,
  input  logic [NUM_SRC*DATA_BITS-1:0]   src_data_r,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic [DATA_BITS-1:0]           out_data_l,
  output logic [DATA_BITS-1:0]           out_data_r,
  output logic [ID_BITS-1:0]             grant_id,
  output logic                           grant_valid,
  output logic [CNT_BITS-1:0]            underrun_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_tick_pend;
  logic                   w_tick_pend_nxt;
  logic [ID_BITS-1:0]     r_rr_ptr;
  logic [ID_BITS-1:0]     r_grant_id;
  logic                   r_grant_valid;
  logic [DATA_BITS-1:0]   r_out_l;
  logic [DATA_BITS-1:0]   r_out_r;
  logic [CNT_BITS-1:0]    r_underrun_cnt;

  logic                   w_found;
  logic [ID_BITS-1:0]     w_pick;
  int                     w_idx;
  logic [NUM_SRC-1:0]     w_valid_sh;
  logic [NUM_SRC-1:0]     w_gvalid_sh;
  logic                   w_grant_src_valid;
  logic [DATA_BITS-1:0]   w_sel_l;
  logic [DATA_BITS-1:0]   w_sel_r;
  logic [ID_BITS-1:0]     w_rr_nxt;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  // Arbitration: scan from the highest search offset down so the lowest
  // offset that has a valid source is the one left in w_pick.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_idx      = 0;
    w_valid_sh = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (mode) begin
        w_idx = k;
      end else begin
        w_idx = (int'(r_rr_ptr) + k) % NUM_SRC;
      end
      w_valid_sh = src_valid >> w_idx;
      if (w_valid_sh[0]) begin
        w_found = 1'b1;
        w_pick  = ID_BITS'(w_idx);
      end
    end
  end

  // Granted source's valid flag, sample words and the round-robin successor.
  always_comb begin
    w_gvalid_sh       = src_valid >> r_grant_id;
    w_grant_src_valid = w_gvalid_sh[0];
    w_sel_l           = DATA_BITS'(src_data_l >> (int'(r_grant_id) * DATA_BITS));
    w_sel_r           = DATA_BITS'(src_data_r >> (int'(r_grant_id) * DATA_BITS));
    if (int'(r_grant_id) == NUM_SRC - 1) begin
      w_rr_nxt = '0;
    end else begin
      w_rr_nxt = r_grant_id + ID_BITS'(1);
    end
  end

  // Ready strobe decoded purely from registered state so it cannot glitch
  // and drops the moment reset clears the state register.
  always_comb begin
    src_ready = '0;
    if (r_state == S_XFER) begin
      src_ready = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_grant_id;
    end
  end

  // FSM next state and pending-tick bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_tick_pend_nxt = r_tick_pend;
    case (r_state)
      S_IDLE: begin
        if (frame_tick || r_tick_pend) begin
          w_state_nxt     = S_ARB;
          w_tick_pend_nxt = 1'b0;
        end
      end
      S_ARB: begin
        w_state_nxt = w_found ? S_XFER : S_IDLE;
        if (frame_tick) w_tick_pend_nxt = 1'b1;
      end
      S_XFER: begin
        w_state_nxt = S_IDLE;
        if (frame_tick) w_tick_pend_nxt = 1'b1;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_tick_pend_nxt = 1'b0;
      end
    endcase
  end

  // FSM state and pending-tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tick_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_pend <= w_tick_pend_nxt;
    end
  end

  // Grant, output sample, round-robin pointer and underrun counter updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr       <= '0;
      r_grant_id     <= '0;
      r_grant_valid  <= 1'b0;
      r_out_l        <= '0;
      r_out_r        <= '0;
      r_underrun_cnt <= '0;
    end else begin
      case (r_state)
        S_ARB: begin
          if (w_found) begin
            r_grant_id    <= w_pick;
            r_grant_valid <= 1'b1;
          end else begin
            r_grant_valid  <= 1'b0;
            r_underrun_cnt <= sat_inc(r_underrun_cnt);
            if ((UNDERRUN_ZERO != 0) || mute) begin
              r_out_l <= '0;
              r_out_r <= '0;
            end
          end
        end
        S_XFER: begin
          if (w_grant_src_valid) begin
            r_out_l  <= mute ? '0 : w_sel_l;
            r_out_r  <= mute ? '0 : w_sel_r;
            r_rr_ptr <= w_rr_nxt;
          end else begin
            // Source withdrew its sample: nothing moves, frame is lost.
            r_grant_valid  <= 1'b0;
            r_underrun_cnt <= sat_inc(r_underrun_cnt);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data_l     = r_out_l;
  assign out_data_r     = r_out_r;
  assign grant_id       = r_grant_id;
  assign grant_valid    = r_grant_valid;
  assign underrun_count = r_underrun_cnt;

endmodule
